// File: rtl/muldivmod_seq.sv
// Iterative radix-2 multiply/divide/modulo sequencer with valid/ready handshakes.
// Optional macro POW2_SHORTCUT_EN: power-of-two B resolves in IDLE via shift/mask.
module muldivmod_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_dbz,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_MOD = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH:0]   r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic [WIDTH-1:0] r_y, w_y_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic             r_in_ready, r_out_valid, r_busy;

    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_q_fix, w_r_fix;
    logic             w_sgn_a, w_sgn_b;
`ifdef POW2_SHORTCUT_EN
    logic             w_pow2;
    logic [CW-1:0]    w_sh;
`endif

    assign w_sgn_a  = in_signed & in_a[WIDTH-1];
    assign w_sgn_b  = in_signed & in_b[WIDTH-1];
    assign w_mag_a  = w_sgn_a ? (~in_a + WIDTH'(1)) : in_a;
    assign w_mag_b  = w_sgn_b ? (~in_b + WIDTH'(1)) : in_b;
    // Restoring division step: remainder shifted with next dividend bit, trial subtract
    assign w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_q_fix  = r_neg_q ? (~r_q + WIDTH'(1)) : r_q;
    assign w_r_fix  = r_neg_r ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];

`ifdef POW2_SHORTCUT_EN
    always_comb begin
        w_sh = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (in_b[i]) w_sh = CW'(i);
        end
        w_pow2 = (in_b != '0) && ((in_b & (in_b - WIDTH'(1))) == '0);
    end
`endif

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_y_nxt     = r_y;
        w_dbz_nxt   = r_dbz;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_op_nxt    = in_op;
                    w_neg_q_nxt = w_sgn_a ^ w_sgn_b;
                    w_neg_r_nxt = w_sgn_a;
                    w_dbz_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    if (in_op == OP_RSV) begin
                        w_y_nxt     = '0;
                        w_state_nxt = S_DONE;
                    end else if (in_op != OP_MUL && in_b == '0) begin
                        w_y_nxt     = (in_op == OP_DIV) ? '1 : in_a;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
`ifdef POW2_SHORTCUT_EN
                    end else if (w_pow2 && (in_op == OP_MUL || !in_signed)) begin
                        unique case (in_op)
                            OP_MUL:  w_y_nxt = in_a << w_sh;
                            OP_DIV:  w_y_nxt = in_a >> w_sh;
                            default: w_y_nxt = in_a & (in_b - WIDTH'(1));
                        endcase
                        w_state_nxt = S_DONE;
`endif
                    end else if (in_op == OP_MUL) begin
                        w_q_nxt     = in_b;
                        w_b_nxt     = in_a;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_q_nxt     = w_mag_a;
                        w_b_nxt     = w_mag_b;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_op == OP_MUL) begin
                    w_acc_nxt = {1'b0, r_acc[WIDTH-1:0] + (r_q[0] ? r_b : '0)};
                    w_b_nxt   = {r_b[WIDTH-2:0], 1'b0};
                    w_q_nxt   = {1'b0, r_q[WIDTH-1:1]};
                end else if (!w_diff[WIDTH]) begin
                    w_acc_nxt = w_diff;
                    w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_nxt = w_rem_sh;
                    w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                unique case (r_op)
                    OP_MUL:  w_y_nxt = r_acc[WIDTH-1:0];
                    OP_DIV:  w_y_nxt = w_q_fix;
                    default: w_y_nxt = w_r_fix;
                endcase
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_op        <= OP_MUL;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_y         <= '0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_q         <= w_q_nxt;
            r_b         <= w_b_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_neg_q     <= w_neg_q_nxt;
            r_neg_r     <= w_neg_r_nxt;
            r_y         <= w_y_nxt;
            r_dbz       <= w_dbz_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_y;
    assign out_dbz   = r_dbz;
    assign busy      = r_busy;

endmodule

// File: tb/tb_muldivmod_seq.sv
// Self-checking bench for muldivmod_seq (WIDTH=8): directed cases plus random ops vs. arithmetic model.
module tb_muldivmod_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_signed, out_valid, out_ready, out_dbz, busy;
    logic [1:0] in_op;
    logic [7:0] in_a, in_b, out_y;

    int n_pass  = 0;
    int n_total = 0;

    muldivmod_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_dbz(out_dbz), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncating division, result taken mod 2^8
    function automatic void model(input logic [1:0] op, input logic s, input logic [7:0] a,
                                  input logic [7:0] b, output logic [7:0] y, output logic dbz);
        int r;
        int sa;
        int sb;
        sa  = s ? int'($signed(a)) : int'(a);
        sb  = s ? int'($signed(b)) : int'(b);
        dbz = 1'b0;
        r   = 0;
        case (op)
            2'd0: r = int'(a) * int'(b);
            2'd1: if (b == 8'd0) begin r = 255; dbz = 1'b1; end else r = sa / sb;
            2'd2: if (b == 8'd0) begin r = int'(a); dbz = 1'b1; end else r = sa % sb;
            default: r = 0;
        endcase
        y = r[7:0];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic s, input logic [7:0] b);
        if (op == 2'd3 || (op != 2'd0 && b == 8'd0)) return 1;
`ifdef POW2_SHORTCUT_EN
        if ($countones(b) == 1 && (op == 2'd0 || !s)) return 1;
`endif
        return 10;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic s,
                          input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] ey;
        logic       ed;
        int         lat;
        int         guard;
        model(op, s, a, b, ey, ed);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_signed = s; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'($urandom); in_signed = 1'($urandom);
        in_a = 8'($urandom); in_b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(op, s, b)));
        chk({tag, "_y"}, 32'(out_y), 32'(ey));
        chk({tag, "_dbz"}, 32'(out_dbz), 32'(ed));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_y"}, 32'(out_y), 32'(ey));
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] b;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_signed = 1'b0;
        in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_dbz", 32'(out_dbz), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("udiv_200_7", 2'd1, 1'b0, 8'd200, 8'd7, 0);
        run_op("umod_200_7", 2'd2, 1'b0, 8'd200, 8'd7, 0);
        run_op("sdiv_m100_8", 2'd1, 1'b1, 8'h9C, 8'd8, 0);
        run_op("smod_m100_8", 2'd2, 1'b1, 8'h9C, 8'd8, 0);
        run_op("sdiv_ovf", 2'd1, 1'b1, 8'h80, 8'hFF, 0);
        run_op("smod_ovf", 2'd2, 1'b1, 8'h80, 8'hFF, 0);
        run_op("div_by_0", 2'd1, 1'b0, 8'h5A, 8'h00, 0);
        run_op("mod_by_0", 2'd2, 1'b1, 8'h5A, 8'h00, 0);
        run_op("reserved", 2'd3, 1'b0, 8'h5A, 8'h11, 0);
        run_op("hold5", 2'd0, 1'b0, 8'd13, 8'd11, 5);
        run_op("udiv_pow2", 2'd1, 1'b0, 8'd200, 8'd8, 0);
        run_op("mul_pow2", 2'd0, 1'b0, 8'h13, 8'd16, 0);
        run_op("smul_neg", 2'd0, 1'b1, 8'hF3, 8'h85, 1);
        run_op("smod_neg_b", 2'd2, 1'b1, 8'd100, 8'hF9, 0);
        run_op("sdiv_pow2_signed", 2'd1, 1'b1, 8'hC8, 8'd4, 0);

        // Reset mid-RUN: the in-flight operation must vanish
        in_valid = 1'b1; in_op = 2'd1; in_signed = 1'b0; in_a = 8'd200; in_b = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: b = 8'd0;
                1: b = 8'(1 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            run_op($sformatf("rand%0d", k), op, 1'($urandom), 8'($urandom), b,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
